apb_fifo_regif: RTL and testbench

- Parametrised single-clock APB3 register interface for serial peripheral cores (I2C, SPI, UART).
- Provides synchronous TX and RX FIFOs, a control register, an address register and a clock-divider register.
- Provides a status register with live flags and write-1-to-clear sticky flags, plus a masked, registered interrupt.
- Sits between the APB bus and the protocol engine; the engine pops TX and pushes RX in the pclk domain.

---
 rtl/apb_fifo_regif.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_apb_fifo_regif.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_fifo_regif.sv
// apb_fifo_regif: APB3 register front-end for serial peripheral engines.
// Holds a TX FIFO (bus pushes, engine pops), an RX FIFO (engine pushes,
// bus pops), control/address/clock-divider registers, a status word made
// of live FIFO flags plus write-1-to-clear sticky flags, and a masked,
// registered interrupt. Everything lives in the pclk domain.

module apb_fifo_regif #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int TX_WM      = 2,
  parameter int RX_WM      = 6,
  parameter int CTRL_W     = 11,
  parameter int ADDR_W     = 10,
  parameter int EVT_W      = 2
) (
  input  logic              i_pclk,
  input  logic              i_n_rst,
  input  logic [31:0]       i_paddr,
  input  logic [31:0]       i_pwdata,
  input  logic              i_psel,
  input  logic              i_penable,
  input  logic              i_pwrite,
  output logic [31:0]       o_prdata,
  output logic              o_pready,
  output logic              o_pslverr,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_pop,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_push,
  input  logic [EVT_W-1:0]  i_evt,
  input  logic              i_ctrl_clr,
  output logic [CTRL_W-1:0] o_control,
  output logic [ADDR_W-1:0] o_address,
  output logic [31:0]       o_clk_div,
  output logic              o_irq
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int STK_W  = 4 + EVT_W;
  localparam int STAT_W = 12 + EVT_W;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] TX_WM_C = CNT_W'(TX_WM);
  localparam logic [CNT_W-1:0] RX_WM_C = CNT_W'(RX_WM);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Word offsets decoded from paddr[4:2]
  localparam logic [2:0] REG_TXDATA = 3'd0;
  localparam logic [2:0] REG_RXDATA = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_ADDR   = 3'd3;
  localparam logic [2:0] REG_CLKDIV = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam logic [2:0] REG_IRQEN  = 3'd6;
  localparam logic [2:0] REG_LEVELS = 3'd7;

  // ---------------------------------------------------------------------
  // APB decode: an access is psel & penable; the setup phase does nothing
  // ---------------------------------------------------------------------
  logic       w_access;
  logic       w_wr;
  logic       w_rd;
  logic [2:0] w_sel;
  logic       w_unused;

  assign w_access = i_psel & i_penable;
  assign w_wr     = w_access & i_pwrite;
  assign w_rd     = w_access & ~i_pwrite;
  assign w_sel    = i_paddr[4:2];
  assign o_pready = 1'b1;
  assign w_unused = &{1'b0, i_paddr[31:5], i_paddr[1:0]};

  // ---------------------------------------------------------------------
  // TX FIFO: written from the bus, drained by the engine
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] r_tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_tx_wr_ptr;
  logic [PTR_W-1:0]  r_tx_rd_ptr;
  logic [CNT_W-1:0]  r_tx_count;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic              w_tx_push_req;
  logic              w_tx_push;
  logic              w_tx_pop;
  logic              w_tx_ovf;
  logic              w_tx_unf;

  assign w_tx_full     = (r_tx_count == DEPTH_C);
  assign w_tx_empty    = (r_tx_count == '0);
  assign w_tx_push_req = w_wr & (w_sel == REG_TXDATA);
  assign w_tx_push     = w_tx_push_req & ~w_tx_full;
  assign w_tx_ovf      = w_tx_push_req & w_tx_full;
  assign w_tx_pop      = i_tx_pop & ~w_tx_empty;
  assign w_tx_unf      = i_tx_pop & w_tx_empty;
  assign o_tx_data     = r_tx_mem[r_tx_rd_ptr];
  assign o_tx_valid    = ~w_tx_empty;

  // TX storage array; contents are only meaningful between the pointers
  always_ff @(posedge i_pclk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= i_pwdata[DATA_W-1:0];
  end

  // TX pointers and occupancy; a simultaneous push and pop keep the count
  always_ff @(posedge i_pclk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
    end else begin
      if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + PTR_ONE;
      if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + PTR_ONE;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + CNT_ONE;
        2'b01:   r_tx_count <= r_tx_count - CNT_ONE;
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // RX FIFO: filled by the engine, drained by RXDATA reads
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] r_rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_rx_wr_ptr;
  logic [PTR_W-1:0]  r_rx_rd_ptr;
  logic [CNT_W-1:0]  r_rx_count;
  logic              w_rx_full;
  logic              w_rx_empty;
  logic              w_rx_pop_req;
  logic              w_rx_push;
  logic              w_rx_pop;
  logic              w_rx_ovf;
  logic              w_rx_unf;
  logic [DATA_W-1:0] w_rx_head;

  assign w_rx_full    = (r_rx_count == DEPTH_C);
  assign w_rx_empty   = (r_rx_count == '0);
  assign w_rx_pop_req = w_rd & (w_sel == REG_RXDATA);
  assign w_rx_push    = i_rx_push & ~w_rx_full;
  assign w_rx_ovf     = i_rx_push & w_rx_full;
  assign w_rx_pop     = w_rx_pop_req & ~w_rx_empty;
  assign w_rx_unf     = w_rx_pop_req & w_rx_empty;
  assign w_rx_head    = r_rx_mem[r_rx_rd_ptr];

  // RX storage array; the read path returns the head before any pop
  always_ff @(posedge i_pclk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= i_rx_data;
  end

  // RX pointers and occupancy, same rules as the TX side
  always_ff @(posedge i_pclk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
    end else begin
      if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + PTR_ONE;
      if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + PTR_ONE;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + CNT_ONE;
        2'b01:   r_rx_count <= r_rx_count - CNT_ONE;
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------
  logic [CTRL_W-1:0] r_control;
  logic [ADDR_W-1:0] r_address;
  logic [31:0]       r_clk_div;
  logic [STAT_W-1:0] r_irq_en;

  // Control register; the engine's clear beats a same-cycle bus write
  always_ff @(posedge i_pclk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_control <= '0;
    end else if (i_ctrl_clr) begin
      r_control <= '0;
    end else if (w_wr && (w_sel == REG_CTRL)) begin
      r_control <= i_pwdata[CTRL_W-1:0];
    end
  end

  // Plain read/write registers: target address, divider, interrupt mask
  always_ff @(posedge i_pclk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_address <= '0;
      r_clk_div <= '0;
      r_irq_en  <= '0;
    end else if (w_wr) begin
      if (w_sel == REG_ADDR)   r_address <= i_pwdata[ADDR_W-1:0];
      if (w_sel == REG_CLKDIV) r_clk_div <= i_pwdata;
      if (w_sel == REG_IRQEN)  r_irq_en  <= i_pwdata[STAT_W-1:0];
    end
  end

  assign o_control = r_control;
  assign o_address = r_address;
  assign o_clk_div = r_clk_div;

  // ---------------------------------------------------------------------
  // Sticky flags: {evt, tx_unf, rx_unf, rx_ovf, tx_ovf} map to status[8+]
  // ---------------------------------------------------------------------
  logic [STK_W-1:0]  r_sticky;
  logic [STK_W-1:0]  w_sticky_set;
  logic [STK_W-1:0]  w_sticky_clr;
  logic [STAT_W-1:0] w_status;

  assign w_sticky_set = {i_evt, w_tx_unf, w_rx_unf, w_rx_ovf, w_tx_ovf};
  assign w_sticky_clr = (w_wr && (w_sel == REG_STATUS)) ? i_pwdata[8 +: STK_W] : '0;

  // W1C clear first, then OR in new events so a coincident set survives
  always_ff @(posedge i_pclk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= (r_sticky & ~w_sticky_clr) | w_sticky_set;
    end
  end

  // Status word: live FIFO flags in the low byte, sticky flags above
  always_comb begin
    w_status           = '0;
    w_status[0]        = w_tx_full;
    w_status[1]        = w_tx_empty;
    w_status[2]        = w_rx_full;
    w_status[3]        = w_rx_empty;
    w_status[4]        = (r_tx_count <= TX_WM_C);
    w_status[5]        = (r_rx_count >= RX_WM_C);
    w_status[8 +: STK_W] = r_sticky;
  end

  // Interrupt is registered, so it trails any status change by one cycle
  always_ff @(posedge i_pclk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      o_irq <= 1'b0;
    end else begin
      o_irq <= |(w_status & r_irq_en);
    end
  end

  // ---------------------------------------------------------------------
  // Read data and error response, driven only during the access cycle
  // ---------------------------------------------------------------------

  // Read mux; RXDATA returns zero when the FIFO has nothing to give
  always_comb begin
    o_prdata = '0;
    if (w_rd) begin
      case (w_sel)
        REG_RXDATA: if (!w_rx_empty) o_prdata = 32'(w_rx_head);
        REG_CTRL:   o_prdata = 32'(r_control);
        REG_ADDR:   o_prdata = 32'(r_address);
        REG_CLKDIV: o_prdata = r_clk_div;
        REG_STATUS: o_prdata = 32'(w_status);
        REG_IRQEN:  o_prdata = 32'(r_irq_en);
        REG_LEVELS: o_prdata = {16'(r_tx_count), 16'(r_rx_count)};
        default:    o_prdata = '0;
      endcase
    end
  end

  // Error on wrong-direction FIFO/LEVELS access, TX overflow, RX underflow
  always_comb begin
    o_pslverr = 1'b0;
    if (w_access) begin
      case (w_sel)
        REG_TXDATA: o_pslverr = ~i_pwrite | w_tx_full;
        REG_RXDATA: o_pslverr = i_pwrite | w_rx_empty;
        REG_LEVELS: o_pslverr = i_pwrite;
        default:    o_pslverr = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_fifo_regif.sv
// tb_apb_fifo_regif: directed, self-checking bench for apb_fifo_regif.
// A linear list of APB transfers and engine-side operations, each followed
// by immediate assertions against hand-computed values.

module tb_apb_fifo_regif;

  localparam logic [31:0] A_TXDATA = 32'h00;
  localparam logic [31:0] A_RXDATA = 32'h04;
  localparam logic [31:0] A_CTRL   = 32'h08;
  localparam logic [31:0] A_ADDR   = 32'h0C;
  localparam logic [31:0] A_CLKDIV = 32'h10;
  localparam logic [31:0] A_STATUS = 32'h14;
  localparam logic [31:0] A_IRQEN  = 32'h18;
  localparam logic [31:0] A_LEVELS = 32'h1C;

  logic        i_pclk;
  logic        i_n_rst;
  logic [31:0] i_paddr;
  logic [31:0] i_pwdata;
  logic        i_psel;
  logic        i_penable;
  logic        i_pwrite;
  logic [31:0] o_prdata;
  logic        o_pready;
  logic        o_pslverr;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_pop;
  logic [7:0]  i_rx_data;
  logic        i_rx_push;
  logic [1:0]  i_evt;
  logic        i_ctrl_clr;
  logic [10:0] o_control;
  logic [9:0]  o_address;
  logic [31:0] o_clk_div;
  logic        o_irq;

  int checkCount = 0;
  int failCount  = 0;

  apb_fifo_regif dut (
    .i_pclk     (i_pclk),
    .i_n_rst    (i_n_rst),
    .i_paddr    (i_paddr),
    .i_pwdata   (i_pwdata),
    .i_psel     (i_psel),
    .i_penable  (i_penable),
    .i_pwrite   (i_pwrite),
    .o_prdata   (o_prdata),
    .o_pready   (o_pready),
    .o_pslverr  (o_pslverr),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_pop   (i_tx_pop),
    .i_rx_data  (i_rx_data),
    .i_rx_push  (i_rx_push),
    .i_evt      (i_evt),
    .i_ctrl_clr (i_ctrl_clr),
    .o_control  (o_control),
    .o_address  (o_address),
    .o_clk_div  (o_clk_div),
    .o_irq      (o_irq)
  );

  // Free-running 100 MHz clock
  initial i_pclk = 1'b0;
  always #5 i_pclk = ~i_pclk;

  // Guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: count it, and on mismatch count and report it
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One APB transfer; optional engine pop / event pulse during the access cycle
  task automatic applyStimulus(input logic write, input logic [31:0] addr,
                               input logic [31:0] data, input logic accessPop,
                               input logic [1:0] accessEvt,
                               output logic [31:0] rdata, output logic err);
    @(negedge i_pclk);
    i_psel    = 1'b1;
    i_penable = 1'b0;
    i_pwrite  = write;
    i_paddr   = addr;
    i_pwdata  = data;
    @(negedge i_pclk);
    i_penable = 1'b1;
    i_tx_pop  = accessPop;
    i_evt     = accessEvt;
    #1;
    rdata = o_prdata;
    err   = o_pslverr;
    @(posedge i_pclk);
    @(negedge i_pclk);
    i_psel    = 1'b0;
    i_penable = 1'b0;
    i_pwrite  = 1'b0;
    i_tx_pop  = 1'b0;
    i_evt     = '0;
  endtask

  task automatic apbWrite(input logic [31:0] addr, input logic [31:0] data,
                          output logic err);
    logic [31:0] unusedRd;
    applyStimulus(1'b1, addr, data, 1'b0, 2'b00, unusedRd, err);
  endtask

  task automatic apbRead(input logic [31:0] addr, output logic [31:0] rdata,
                         output logic err);
    applyStimulus(1'b0, addr, 32'h0, 1'b0, 2'b00, rdata, err);
  endtask

  // Engine pops the TX head, returning what it saw before the pop
  task automatic enginePop(output logic [7:0] data);
    @(negedge i_pclk);
    data     = o_tx_data;
    i_tx_pop = 1'b1;
    @(negedge i_pclk);
    i_tx_pop = 1'b0;
  endtask

  task automatic enginePush(input logic [7:0] data);
    @(negedge i_pclk);
    i_rx_data = data;
    i_rx_push = 1'b1;
    @(negedge i_pclk);
    i_rx_push = 1'b0;
  endtask

  task automatic pulseEvt(input logic [1:0] bits);
    @(negedge i_pclk);
    i_evt = bits;
    @(negedge i_pclk);
    i_evt = '0;
  endtask

  logic [31:0] rd;
  logic        err;
  logic [7:0]  b;

  // Directed sequence
  initial begin
    i_n_rst    = 1'b0;
    i_paddr    = '0;
    i_pwdata   = '0;
    i_psel     = 1'b0;
    i_penable  = 1'b0;
    i_pwrite   = 1'b0;
    i_tx_pop   = 1'b0;
    i_rx_data  = '0;
    i_rx_push  = 1'b0;
    i_evt      = '0;
    i_ctrl_clr = 1'b0;

    // ---- Reset state ----
    repeat (3) @(negedge i_pclk);
    checkOutput("rst_irq", 32'(o_irq), 32'h0);
    checkOutput("rst_control", 32'(o_control), 32'h0);
    checkOutput("rst_tx_valid", 32'(o_tx_valid), 32'h0);
    checkOutput("rst_prdata", o_prdata, 32'h0);
    checkOutput("rst_pslverr", 32'(o_pslverr), 32'h0);
    checkOutput("rst_clk_div", o_clk_div, 32'h0);
    checkOutput("pready", 32'(o_pready), 32'h1);
    i_n_rst = 1'b1;

    // tx_empty | rx_empty | tx_low
    apbRead(A_STATUS, rd, err);
    checkOutput("rst_status", rd, 32'h0000_001A);
    checkOutput("rst_status_err", 32'(err), 32'h0);

    // ---- TX overflow ----
    for (int i = 1; i <= 8; i++) begin
      apbWrite(A_TXDATA, 32'(i), err);
      checkOutput("tx_push_err", 32'(err), 32'h0);
    end
    apbWrite(A_TXDATA, 32'h09, err);
    checkOutput("tx_ovf_err", 32'(err), 32'h1);
    apbRead(A_STATUS, rd, err);
    checkOutput("tx_ovf_status", rd, 32'h0000_0109);
    apbRead(A_LEVELS, rd, err);
    checkOutput("tx_full_levels", rd, 32'h0008_0000);
    checkOutput("tx_ovf_irq_masked", 32'(o_irq), 32'h0);
    for (int i = 1; i <= 8; i++) begin
      enginePop(b);
      checkOutput("tx_pop_data", 32'(b), 32'(i));
    end
    checkOutput("tx_drained_valid", 32'(o_tx_valid), 32'h0);
    apbRead(A_STATUS, rd, err);
    checkOutput("tx_drained_status", rd, 32'h0000_011A);
    apbWrite(A_STATUS, 32'h0000_0100, err);
    apbRead(A_STATUS, rd, err);
    checkOutput("tx_ovf_w1c", rd, 32'h0000_001A);

    // ---- RX overflow and underflow ----
    for (int i = 0; i < 9; i++) enginePush(8'hA0 + 8'(i));
    apbRead(A_STATUS, rd, err);
    checkOutput("rx_ovf_status", rd, 32'h0000_0236);
    apbRead(A_LEVELS, rd, err);
    checkOutput("rx_full_levels", rd, 32'h0000_0008);
    for (int i = 0; i < 8; i++) begin
      apbRead(A_RXDATA, rd, err);
      checkOutput("rx_read_data", rd, 32'hA0 + 32'(i));
      checkOutput("rx_read_err", 32'(err), 32'h0);
    end
    apbRead(A_RXDATA, rd, err);
    checkOutput("rx_unf_data", rd, 32'h0);
    checkOutput("rx_unf_err", 32'(err), 32'h1);
    apbRead(A_STATUS, rd, err);
    checkOutput("rx_unf_status", rd, 32'h0000_061A);
    apbWrite(A_STATUS, 32'h0000_0600, err);
    apbRead(A_STATUS, rd, err);
    checkOutput("rx_w1c", rd, 32'h0000_001A);

    // ---- Interrupt masking ----
    apbWrite(A_IRQEN, 32'h0000_1000, err);
    apbRead(A_IRQEN, rd, err);
    checkOutput("irqen_readback", rd, 32'h0000_1000);
    pulseEvt(2'b01);
    checkOutput("irq_same_cycle", 32'(o_irq), 32'h0);
    @(negedge i_pclk);
    checkOutput("irq_next_cycle", 32'(o_irq), 32'h1);
    apbRead(A_STATUS, rd, err);
    checkOutput("evt0_status", rd, 32'h0000_101A);
    apbWrite(A_STATUS, 32'h0000_1000, err);
    checkOutput("irq_w1c_lag", 32'(o_irq), 32'h1);
    @(negedge i_pclk);
    checkOutput("irq_w1c_clear", 32'(o_irq), 32'h0);
    pulseEvt(2'b01);
    @(negedge i_pclk);
    checkOutput("irq_reassert", 32'(o_irq), 32'h1);
    applyStimulus(1'b1, A_STATUS, 32'h0000_1000, 1'b0, 2'b01, rd, err);
    @(negedge i_pclk);
    checkOutput("irq_set_wins", 32'(o_irq), 32'h1);
    apbRead(A_STATUS, rd, err);
    checkOutput("set_wins_status", rd, 32'h0000_101A);
    apbWrite(A_STATUS, 32'h0000_1000, err);
    apbWrite(A_IRQEN, 32'h0, err);
    @(negedge i_pclk);
    checkOutput("irq_cleanup", 32'(o_irq), 32'h0);

    // ---- Same-cycle FIFO operations ----
    for (int i = 0; i < 8; i++) apbWrite(A_TXDATA, 32'h10 + 32'(i), err);
    applyStimulus(1'b1, A_TXDATA, 32'h99, 1'b1, 2'b00, rd, err);
    checkOutput("full_push_pop_err", 32'(err), 32'h1);
    apbRead(A_LEVELS, rd, err);
    checkOutput("full_push_pop_levels", rd, 32'h0007_0000);
    apbRead(A_STATUS, rd, err);
    checkOutput("full_push_pop_status", rd, 32'h0000_0108);
    for (int i = 1; i < 8; i++) begin
      enginePop(b);
      checkOutput("after_ovf_pop_data", 32'(b), 32'h10 + 32'(i));
    end
    checkOutput("after_ovf_valid", 32'(o_tx_valid), 32'h0);
    apbWrite(A_STATUS, 32'h0000_0100, err);
    applyStimulus(1'b1, A_TXDATA, 32'h42, 1'b1, 2'b00, rd, err);
    checkOutput("empty_push_pop_err", 32'(err), 32'h0);
    apbRead(A_LEVELS, rd, err);
    checkOutput("empty_push_pop_levels", rd, 32'h0001_0000);
    apbRead(A_STATUS, rd, err);
    checkOutput("empty_push_pop_status", rd, 32'h0000_0818);
    checkOutput("empty_push_pop_head", 32'(o_tx_data), 32'h42);
    enginePop(b);
    apbWrite(A_STATUS, 32'h0000_0800, err);

    // ---- Register behaviour ----
    apbWrite(A_CTRL, 32'hFFFF_FFFF, err);
    checkOutput("ctrl_write", 32'(o_control), 32'h0000_07FF);
    apbRead(A_CTRL, rd, err);
    checkOutput("ctrl_readback", rd, 32'h0000_07FF);
    i_ctrl_clr = 1'b1;
    apbWrite(A_CTRL, 32'h0000_07FF, err);
    i_ctrl_clr = 1'b0;
    checkOutput("ctrl_clr_priority", 32'(o_control), 32'h0);
    apbWrite(A_ADDR, 32'hFFFF_FEA5, err);
    checkOutput("addr_write", 32'(o_address), 32'h0000_02A5);
    apbRead(A_ADDR, rd, err);
    checkOutput("addr_readback", rd, 32'h0000_02A5);
    apbWrite(A_CLKDIV, 32'hDEAD_BEEF, err);
    checkOutput("clkdiv_write", o_clk_div, 32'hDEAD_BEEF);
    apbRead(A_CLKDIV, rd, err);
    checkOutput("clkdiv_readback", rd, 32'hDEAD_BEEF);
    apbRead(A_TXDATA, rd, err);
    checkOutput("txdata_read_err", 32'(err), 32'h1);
    checkOutput("txdata_read_data", rd, 32'h0);
    apbWrite(A_RXDATA, 32'h0, err);
    checkOutput("rxdata_write_err", 32'(err), 32'h1);
    apbWrite(A_LEVELS, 32'h0, err);
    checkOutput("levels_write_err", 32'(err), 32'h1);
    apbWrite(A_CTRL, 32'h0000_0123, err);
    checkOutput("ctrl_plain_err", 32'(err), 32'h0);

    // ---- Reset asserted mid-stream ----
    apbWrite(A_TXDATA, 32'h55, err);
    enginePush(8'h66);
    apbWrite(A_IRQEN, 32'h0000_2000, err);
    pulseEvt(2'b10);
    @(negedge i_pclk);
    checkOutput("pre_reset_irq", 32'(o_irq), 32'h1);
    i_n_rst = 1'b0;
    #1;
    checkOutput("mid_rst_tx_valid", 32'(o_tx_valid), 32'h0);
    checkOutput("mid_rst_irq", 32'(o_irq), 32'h0);
    checkOutput("mid_rst_control", 32'(o_control), 32'h0);
    checkOutput("mid_rst_clk_div", o_clk_div, 32'h0);
    @(negedge i_pclk);
    i_n_rst = 1'b1;
    apbRead(A_STATUS, rd, err);
    checkOutput("post_rst_status", rd, 32'h0000_001A);
    apbRead(A_LEVELS, rd, err);
    checkOutput("post_rst_levels", rd, 32'h0);
    apbRead(A_IRQEN, rd, err);
    checkOutput("post_rst_irqen", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
